// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequenced
// binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ_THRESHOLD = 4'd5;

endpackage

// File: rtl/bin2bcd_sequencer_if.sv
// Operand/result handshake bundle for bin2bcd_sequencer.
// master = producer/consumer side, slave = converter.
interface bin2bcd_sequencer_if #(
  parameter int binaryNumberWidth = 32,
  parameter int numberOfDigits    = 10
);
  import bin2bcd_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [binaryNumberWidth-1:0] binaryNumber;
  logic                         out_valid;
  logic                         out_ready;
  bcd_digit_t [numberOfDigits-1:0] BinaryDecimal;
  logic                         overflow;
  logic                         busy;

  modport master (
    output in_valid,
    output binaryNumber,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  BinaryDecimal,
    input  overflow,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  binaryNumber,
    input  out_ready,
    output in_ready,
    output out_valid,
    output BinaryDecimal,
    output overflow,
    output busy
  );

endinterface

// File: rtl/bin2bcd_sequencer_adj3.sv
// Double-dabble digit correction: add 3 to a
// BCD digit of 5 or more before it is doubled.
module bcd_digit_adj3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESHOLD)
                 ? i_digit + 4'd3
                 : i_digit;

endmodule

// File: rtl/bin2bcd_sequencer.sv
// Sequenced double-dabble converter, one operand
// bit per clock, valid/ready on both sides.
module bin2bcd_sequencer
  import bin2bcd_pkg::*;
#(
  parameter int binaryNumberWidth = 32,
  parameter int numberOfDigits    = 10
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_sequencer_if.slave bus
);

  localparam int W  = binaryNumberWidth;
  localparam int D  = numberOfDigits;
  localparam int CW = $clog2(W);
  localparam int N  = 4 * D + W;

  bcd_state_t           r_state;
  bcd_state_t           w_next;
  logic [CW-1:0]        r_cnt;
  logic [W-1:0]         r_shreg;
  bcd_digit_t [D-1:0]   r_acc;
  logic                 r_ovf;

  bcd_digit_t [D-1:0]   w_adj;
  logic [N-1:0]         w_cat;
  logic [N-1:0]         w_shl;
  logic                 w_accept;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj3 u_adj (
      .i_digit (r_acc[g]),
      .o_digit (w_adj[g])
    );
  end

  assign w_cat = {w_adj, r_shreg};
  assign w_shl = {w_cat[N-2:0], 1'b0};

  assign bus.in_ready = (r_state == IDLE) ||
                        ((r_state == DONE) && bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.in_valid) w_next = CONV;
      CONV: if (r_cnt == '0)  w_next = DONE;
      DONE: if (bus.out_ready)
              w_next = bus.in_valid ? CONV : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CW'(W - 1);
      r_shreg <= bus.binaryNumber;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == CONV) begin
      r_shreg <= w_shl[W-1:0];
      r_acc   <= w_shl[N-1:W];
      // a carry out of the top digit is one lost 10^D
      if (w_cat[N-1]) r_ovf <= 1'b1;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.out_valid     = (r_state == DONE);
  assign bus.busy          = (r_state == CONV);
  assign bus.BinaryDecimal = r_acc;
  assign bus.overflow      = r_ovf;

endmodule

// File: tb/tb_bin2bcd_sequencer.sv
// Directed bench: default 32/10 instance plus a
// narrow 12/3 instance for overflow cases.
module tb_bin2bcd_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bin2bcd_sequencer_if #(32, 10) a ();
  bin2bcd_sequencer_if #(12, 3)  b ();

  bin2bcd_sequencer #(
    .binaryNumberWidth (32),
    .numberOfDigits    (10)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  bin2bcd_sequencer #(
    .binaryNumberWidth (12),
    .numberOfDigits    (3)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [31:0] v,
                       output int lat);
    a.binaryNumber = v;
    a.in_valid     = 1'b1;
    step();
    a.in_valid = 1'b0;
    lat = 1;
    while (!a.out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_b(input logic [11:0] v,
                       output int lat);
    b.binaryNumber = v;
    b.in_valid     = 1'b1;
    step();
    b.in_valid = 1'b0;
    lat = 1;
    while (!b.out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic retire_a();
    a.out_ready = 1'b1;
    step();
    a.out_ready = 1'b0;
  endtask

  task automatic retire_b();
    b.out_ready = 1'b1;
    step();
    b.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 ||
        a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b want 1 0 0",
               a.in_ready, a.out_valid, a.busy);
    end
    n_chk++;
    if (a.BinaryDecimal !== 40'h0 || a.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h ovf=%b want 0 0",
               a.BinaryDecimal, a.overflow);
    end
  endtask

  task automatic test_zero();
    int lat;
    run_a(32'd0, lat);
    n_chk++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d want 33", lat);
    end
    n_chk++;
    if (a.BinaryDecimal !== 40'h0 || a.overflow !== 1'b0 ||
        a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_result: got %h ovf=%b busy=%b want 0 0 0",
               a.BinaryDecimal, a.overflow, a.busy);
    end
    retire_a();
  endtask

  task automatic test_values();
    int lat;
    run_a(32'd255, lat);
    n_chk++;
    if (a.BinaryDecimal !== 40'h0000000255 ||
        a.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL val_255: got %h ovf=%b want 0000000255 0",
               a.BinaryDecimal, a.overflow);
    end
    retire_a();
    run_a(32'hFFFF_FFFF, lat);
    n_chk++;
    if (a.BinaryDecimal !== 40'h4294967295 ||
        a.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL val_max: got %h ovf=%b want 4294967295 0",
               a.BinaryDecimal, a.overflow);
    end
    retire_a();
  endtask

  task automatic test_narrow();
    int lat;
    run_b(12'd999, lat);
    n_chk++;
    if (b.BinaryDecimal !== 12'h999 || b.overflow !== 1'b0 ||
        lat !== 13) begin
      n_fail++;
      $display("FAIL n_999: got %h ovf=%b lat=%0d want 999 0 13",
               b.BinaryDecimal, b.overflow, lat);
    end
    retire_b();
    run_b(12'd1000, lat);
    n_chk++;
    if (b.BinaryDecimal !== 12'h000 || b.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL n_1000: got %h ovf=%b want 000 1",
               b.BinaryDecimal, b.overflow);
    end
    retire_b();
    run_b(12'd4095, lat);
    n_chk++;
    if (b.BinaryDecimal !== 12'h095 || b.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL n_4095: got %h ovf=%b want 095 1",
               b.BinaryDecimal, b.overflow);
    end
    retire_b();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_a(32'd1234567890, lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (a.BinaryDecimal !== 40'h1234567890 ||
          a.out_valid !== 1'b1 || a.in_ready !== 1'b0) begin
        n_fail++;
        bad++;
        if (bad < 4)
          $display("FAIL bp_hold: cyc %0d got %h v=%b r=%b want 1234567890 1 0",
                   i, a.BinaryDecimal, a.out_valid, a.in_ready);
      end
      step();
    end
    a.out_ready = 1'b1;
    #1;
    n_chk++;
    if (a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready: got %b want 1", a.in_ready);
    end
    step();
    a.out_ready = 1'b0;
    n_chk++;
    if (a.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drop: got %b want 0", a.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [3];
    logic [39:0] exp_r [3];
    logic [39:0] res [3];
    int          at [3];
    int          idx;
    int          got;
    int          cyc;
    logic        acc;
    ops[0] = 32'd1;
    ops[1] = 32'd10;
    ops[2] = 32'd100;
    exp_r[0] = 40'h1;
    exp_r[1] = 40'h10;
    exp_r[2] = 40'h100;
    for (int i = 0; i < 3; i++) begin
      res[i] = '0;
      at[i]  = 0;
    end
    idx = 0;
    got = 0;
    cyc = 0;
    a.out_ready    = 1'b1;
    a.in_valid     = 1'b1;
    a.binaryNumber = ops[0];
    while (got < 3 && cyc < 300) begin
      acc = a.in_valid && a.in_ready;
      if (a.out_valid) begin
        res[got] = a.BinaryDecimal;
        at[got]  = cyc;
        got++;
      end
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) a.binaryNumber = ops[idx];
        else a.in_valid = 1'b0;
      end
    end
    a.out_ready = 1'b0;
    a.in_valid  = 1'b0;
    n_chk++;
    if (got !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 3", got);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (res[i] !== exp_r[i]) begin
        n_fail++;
        $display("FAIL b2b_res%0d: got %h want %h",
                 i, res[i], exp_r[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_chk++;
      if (at[i] - at[i-1] !== 33) begin
        n_fail++;
        $display("FAIL b2b_gap%0d: got %0d want 33",
                 i, at[i] - at[i-1]);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    a.binaryNumber = 32'd987654321;
    a.in_valid     = 1'b1;
    step();
    a.in_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    n_chk++;
    if (a.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: got %b want 1", a.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (a.busy !== 1'b0 || a.out_valid !== 1'b0 ||
        a.in_ready !== 1'b1 || a.BinaryDecimal !== 40'h0 ||
        a.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b v=%b r=%b d=%h o=%b want 0 0 1 0 0",
               a.busy, a.out_valid, a.in_ready,
               a.BinaryDecimal, a.overflow);
    end
    step();
    rst_n = 1'b1;
    step();
    run_a(32'd42, lat);
    n_chk++;
    if (a.BinaryDecimal !== 40'h42 || a.overflow !== 1'b0 ||
        lat !== 33) begin
      n_fail++;
      $display("FAIL abort_42: got %h ovf=%b lat=%0d want 42 0 33",
               a.BinaryDecimal, a.overflow, lat);
    end
    retire_a();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    a.in_valid = 1'b0;
    a.out_ready = 1'b0;
    a.binaryNumber = '0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b0;
    b.binaryNumber = '0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_zero();
    test_values();
    test_narrow();
    test_backpressure();
    step();
    test_back_to_back();
    step();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
